// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word-aligned fetches, buffers
// returned instructions for decode and discards responses made stale by a
// redirect or reset.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc;
  // outstanding counts every accepted request still awaiting its response,
  // including the stale ones that drop_cnt marks for discard.
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [CW-1:0] remaining;

  logic [31:0]   addr_q  [QDEPTH];
  logic [AW-1:0] addr_wr;
  logic [AW-1:0] addr_rd;

  logic [31:0]   instr_q [QDEPTH];
  logic [31:0]   pc_q    [QDEPTH];
  logic [AW-1:0] fifo_wr;
  logic [AW-1:0] fifo_rd;

  logic req_fire;
  logic rsp_drop;
  logic push;
  logic pop;

  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Request credit, response routing and decode-side outputs.
  always_comb begin
    remaining = outstanding;
    if (imem_rsp_valid && (outstanding != '0)) begin
      remaining = outstanding - CW'(1);
    end
    imem_req_valid = !rst && !redirect_valid &&
                     ((SW'(outstanding) + SW'(count)) < SW'(QDEPTH));
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
    push           = imem_rsp_valid && (drop_cnt == '0) && !rst && !redirect_valid;
    id_valid       = !rst && (count != '0);
    pop            = id_valid && id_ready && !redirect_valid;
    id_instr       = NOP;
    id_pc          = 32'h0000_0000;
    if (id_valid) begin
      id_instr = instr_q[fifo_rd];
      id_pc    = pc_q[fifo_rd];
    end
    id_pc_plus4 = id_pc + 32'd4;
  end

  // Control state: PC, counters and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Pre-reset requests stay counted so their late responses get dropped.
      pc          <= RESET_PC;
      count       <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      outstanding <= remaining;
      drop_cnt    <= remaining;
      addr_rd     <= '0;
      addr_wr     <= AW'(remaining);
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the wrong path.
      pc          <= {redirect_pc[31:2], 2'b00};
      count       <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      outstanding <= remaining;
      drop_cnt    <= remaining;
      if (imem_rsp_valid) begin
        addr_rd <= addr_rd + AW'(1);
      end
    end else begin
      if (req_fire) begin
        pc      <= pc + 32'd4;
        addr_wr <= addr_wr + AW'(1);
      end
      if (imem_rsp_valid) begin
        addr_rd <= addr_rd + AW'(1);
      end
      if (push) begin
        fifo_wr <= fifo_wr + AW'(1);
      end
      if (pop) begin
        fifo_rd <= fifo_rd + AW'(1);
      end
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      drop_cnt    <= drop_cnt - CW'(rsp_drop);
    end
  end

  // Address and instruction storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      addr_q[addr_wr] <= pc;
    end
    if (push) begin
      instr_q[fifo_wr] <= imem_rsp_data;
      pc_q[fifo_wr]    <= addr_q[addr_rd];
    end
  end

  // Memory-side protocol checks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count == CW'(QDEPTH))))
        else $error("fetch_stage: response arrived with fetch FIFO full");
      assert (!(imem_rsp_valid && (outstanding == '0)))
        else $error("fetch_stage: response arrived with nothing outstanding");
    end
  end

endmodule
